multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32 control FSM with memory wait timeout and error halt
// Optional BRANCH_EXT_EN enables bne/blt/bge/bltu/bgeu; default build supports beq only.
module multicycle_ctrl #(
    parameter int ALU_CTRL_W  = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  zero,
    input  logic                  lt,
    input  logic                  ltu,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [2:0]            imm_src,
    output logic                  reg_write,
    output logic                  halted,
    output logic [1:0]            err_code
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = ALU_CTRL_W'(3);
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = ALU_CTRL_W'(4);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = ALU_CTRL_W'(5);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(6);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = ALU_CTRL_W'(7);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = ALU_CTRL_W'(8);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = ALU_CTRL_W'(9);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_EXECLUI, S_ALUWB, S_BRANCH, S_JALR_ADR, S_JAL, S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       err_q, err_d;
    logic             br_legal;
    logic             br_taken;
    logic             in_wait;
    logic [ALU_CTRL_W-1:0] alu_op;

`ifdef BRANCH_EXT_EN
    always_comb begin
        br_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = !zero;
            3'b100:  br_taken = lt;
            3'b101:  br_taken = !lt;
            3'b110:  br_taken = ltu;
            3'b111:  br_taken = !ltu;
            default: br_taken = 1'b0;
        endcase
    end
`else
    logic unused_cmp;
    assign unused_cmp = lt ^ ltu;
    assign br_legal   = (funct3 == 3'b000);
    assign br_taken   = zero;
`endif

    // Subtract only for R-type (op[5]) with funct7[5]; addi never subtracts.
    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'b000:  alu_op = (op[5] && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    end

    always_comb begin
        imm_src = 3'b000;
        case (op)
            OP_STORE: imm_src = 3'b001;
            OP_BR:    imm_src = 3'b010;
            OP_JAL:   imm_src = 3'b011;
            OP_LUI:   imm_src = 3'b100;
            default:  imm_src = 3'b000;
        endcase
    end

    assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        cnt_d       = '0;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        reg_write   = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_LUI:            state_d = S_EXECLUI;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR_ADR;
                    OP_BR:             state_d = br_legal ? S_BRANCH : S_ERROR;
                    default:           state_d = S_ERROR;
                endcase
                if (state_d == S_ERROR) err_d = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_op;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_op;
                state_d     = S_ALUWB;
            end
            S_EXECLUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write    = br_taken;
                state_d     = S_FETCH;
            end
            S_JALR_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = S_JAL;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase

        // Counter only survives consecutive not-ready cycles in one access state.
        if (in_wait && !mem_ready) begin
            if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                state_d = S_ERROR;
                err_d   = 2'b10;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign halted   = (state_q == S_ERROR);
    assign err_code = err_q;

endmodule
